// File: rtl/sd_cmd_monitor.sv
// rtl/sd_cmd_monitor.sv - passive SD CMD-line frame monitor with FIFO output
// Optional CRC7 checking is enabled by defining SDMON_CRC_CHECK_EN.
module sd_cmd_monitor #(
    parameter int FIFO_ASIZE = 3,
    parameter int TS_WIDTH   = 32,
    parameter int LONG_RESP  = 1,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sdclk,
    input  logic                  sdcmd,
    output logic                  ovalid,
    input  logic                  oready,
    output logic [135:0]          odata,
    output logic                  olong,
    output logic                  odir,
    output logic                  otrunc,
    output logic                  ocrc_ok,
    output logic [TS_WIDTH-1:0]   ots,
    output logic [DROP_WIDTH-1:0] odrop
);

    localparam int DEPTH = 1 << FIFO_ASIZE;

    typedef enum logic [1:0] {S_IDLE, S_CAPT, S_SKIP, S_PUSH} state_t;

    typedef struct packed {
        logic [135:0]        data;
        logic                lng;
        logic                dir;
        logic                trunc;
        logic                crc_ok;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    // clk_sync_q[1:0] synchronise sdclk, clk_sync_q[2] holds the previous synced value
    logic [2:0]            clk_sync_q, clk_sync_d;
    logic [1:0]            cmd_sync_q, cmd_sync_d;
    state_t                state_q, state_d;
    logic [7:0]            bitcnt_q, bitcnt_d;
    logic [135:0]          shift_q, shift_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d, ts_lat_q, ts_lat_d;
    logic                  dir_q, dir_d, trunc_q, trunc_d;
    logic [5:0]            last_idx_q, last_idx_d;
    logic [FIFO_ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
`ifdef SDMON_CRC_CHECK_EN
    logic [6:0]            crc_q, crc_d;
`endif

    logic   strobe, cmd_bit, dir_eff, r2_resp, long_frame, crc_match;
    logic   push, empty, full, pop, wr_en;
    entry_t push_entry, head;
    entry_t fifo_mem_q [DEPTH];

    assign strobe  = clk_sync_q[1] & ~clk_sync_q[2];
    assign cmd_bit = cmd_sync_q[1];

    // Until the transmission bit has been registered, use the bit arriving now.
    assign dir_eff    = (bitcnt_q == 8'd1) ? cmd_bit : dir_q;
    assign r2_resp    = !dir_eff && (last_idx_q == 6'd2 || last_idx_q == 6'd9 || last_idx_q == 6'd10);
    assign long_frame = r2_resp && (LONG_RESP != 0);

`ifdef SDMON_CRC_CHECK_EN
    assign crc_match = (crc_q == shift_q[7:1]);
`else
    assign crc_match = 1'b1;
`endif

    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], sdclk};
        cmd_sync_d = {cmd_sync_q[0], sdcmd};
        ts_d       = ts_q + TS_WIDTH'(1);
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        ts_lat_d   = ts_lat_q;
        dir_d      = dir_q;
        trunc_d    = trunc_q;
        last_idx_d = last_idx_q;
        push       = 1'b0;
`ifdef SDMON_CRC_CHECK_EN
        crc_d      = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (strobe && !cmd_bit) begin
                    state_d  = S_CAPT;
                    bitcnt_d = 8'd1;
                    shift_d  = '0;
                    ts_lat_d = ts_q;
                    trunc_d  = 1'b0;
`ifdef SDMON_CRC_CHECK_EN
                    crc_d    = '0;
`endif
                end
            end
            S_CAPT: begin
                if (strobe) begin
                    shift_d  = {shift_q[134:0], cmd_bit};
                    bitcnt_d = bitcnt_q + 8'd1;
                    if (bitcnt_q == 8'd1)
                        dir_d = cmd_bit;
`ifdef SDMON_CRC_CHECK_EN
                    // The start bit is never fed; a zero bit into a zero register is a no-op anyway.
                    if (long_frame ? (bitcnt_q >= 8'd8 && bitcnt_q <= 8'd127) : (bitcnt_q <= 8'd39))
                        crc_d = {crc_q[5:0], 1'b0} ^ ({7{cmd_bit ^ crc_q[6]}} & 7'h09);
`endif
                    if (long_frame) begin
                        if (bitcnt_q == 8'd135)
                            state_d = S_PUSH;
                    end else if (bitcnt_q == 8'd47) begin
                        if (r2_resp) begin
                            trunc_d  = 1'b1;
                            bitcnt_d = '0;
                            state_d  = S_SKIP;
                        end else begin
                            state_d = S_PUSH;
                        end
                    end
                end
            end
            S_SKIP: begin
                if (strobe) begin
                    bitcnt_d = bitcnt_q + 8'd1;
                    if (bitcnt_q == 8'd87)
                        state_d = S_PUSH;
                end
            end
            default: begin
                push    = 1'b1;
                state_d = S_IDLE;
                if (dir_q)
                    last_idx_d = shift_q[45:40];
            end
        endcase
    end

    always_comb begin
        push_entry       = '0;
        push_entry.data  = shift_q;
        push_entry.lng   = long_frame && !trunc_q;
        push_entry.dir   = dir_q;
        push_entry.trunc = trunc_q;
        push_entry.ts    = ts_lat_q;
        if (trunc_q)
            push_entry.crc_ok = 1'b1;
        else if (long_frame)
            push_entry.crc_ok = crc_match;
        else
            push_entry.crc_ok = crc_match & shift_q[0];
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_ASIZE] != rptr_q[FIFO_ASIZE]) &&
                   (wptr_q[FIFO_ASIZE-1:0] == rptr_q[FIFO_ASIZE-1:0]);
    assign pop   = !empty && oready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        wptr_d = wr_en ? wptr_q + (FIFO_ASIZE+1)'(1) : wptr_q;
        rptr_d = pop ? rptr_q + (FIFO_ASIZE+1)'(1) : rptr_q;
        drop_d = drop_q;
        if (push && !wr_en && drop_q != '1)
            drop_d = drop_q + DROP_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 3'b111;
            cmd_sync_q <= 2'b11;
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            ts_q       <= '0;
            ts_lat_q   <= '0;
            dir_q      <= 1'b0;
            trunc_q    <= 1'b0;
            last_idx_q <= 6'h3F;
            wptr_q     <= '0;
            rptr_q     <= '0;
            drop_q     <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            cmd_sync_q <= cmd_sync_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            ts_q       <= ts_d;
            ts_lat_q   <= ts_lat_d;
            dir_q      <= dir_d;
            trunc_q    <= trunc_d;
            last_idx_q <= last_idx_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            drop_q     <= drop_d;
        end
    end

`ifdef SDMON_CRC_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            crc_q <= '0;
        else
            crc_q <= crc_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem_q[wptr_q[FIFO_ASIZE-1:0]] <= push_entry;
    end

    // Head fields are forced to zero when empty so reset and drained states read as all-zero.
    assign head    = fifo_mem_q[rptr_q[FIFO_ASIZE-1:0]];
    assign ovalid  = !empty;
    assign odata   = ovalid ? head.data : '0;
    assign olong   = ovalid & head.lng;
    assign odir    = ovalid & head.dir;
    assign otrunc  = ovalid & head.trunc;
    assign ocrc_ok = ovalid & head.crc_ok;
    assign ots     = ovalid ? head.ts : '0;
    assign odrop   = drop_q;

endmodule
